// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares a two-bank SRAM array (2 banks x 4 byte lanes)
// between the AHB-side port p0 and a secondary master p1. One access per cycle.
// Arbitration is round-robin with a lock/burst hold bounded by MAX_HOLD.
// Read data is returned on the requesting port one cycle after the grant.
// Optional build macro: ARB_FIXED_PRIO_EN (ties always go to p0).
module sram_port_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HCNT_W   = 4
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [15:0] p0_addr,
  input  logic [3:0]  p0_be,
  input  logic [31:0] p0_wdata,
  input  logic        p0_lock,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [15:0] p1_addr,
  input  logic [3:0]  p1_be,
  input  logic [31:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  input  logic [7:0]  sram_q0,
  input  logic [7:0]  sram_q1,
  input  logic [7:0]  sram_q2,
  input  logic [7:0]  sram_q3,
  input  logic [7:0]  sram_q4,
  input  logic [7:0]  sram_q5,
  input  logic [7:0]  sram_q6,
  input  logic [7:0]  sram_q7,
  output logic        sram_w_en,
  output logic [12:0] sram_addr_out,
  output logic [31:0] sram_wdata,
  output logic [3:0]  bank0_csn,
  output logic [3:0]  bank1_csn
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t              state, state_nxt;
  logic                last_gnt, last_gnt_nxt;
  logic [HCNT_W-1:0]   hold_cnt, hold_cnt_nxt;

  logic                tie_p1;
  logic                arb_g0, arb_g1;

  logic                acc;
  logic                sel_wr;
  logic [15:0]         sel_addr;
  logic [3:0]          sel_be;
  logic [31:0]         sel_wdata;

  logic                rd_pend;
  logic                rd_port;
  logic                rd_bank;
  logic [3:0]          rd_be;
  logic [31:0]         bank_word;
  logic [31:0]         rd_word;

  logic                unused_addr_bits;

  assign unused_addr_bits = ^{p0_addr[1:0], p1_addr[1:0]};

  // Free arbitration winner, used in IDLE and when an owner releases
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    tie_p1 = 1'b0;
`else
    tie_p1 = ~last_gnt;
`endif
    arb_g0 = p0_req & (~p1_req | ~tie_p1);
    arb_g1 = p1_req & (~p0_req |  tie_p1);
  end

  // Next-state, grant and hold-counter logic
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    hold_cnt_nxt = hold_cnt;
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    case (state)
      OWN0: begin
        if (p0_req && (!p1_req || hold_cnt < HCNT_W'(MAX_HOLD))) begin
          p0_gnt       = 1'b1;
          last_gnt_nxt = 1'b0;
          hold_cnt_nxt = p1_req ? hold_cnt + 1'b1 : '0;
          state_nxt    = p0_lock ? OWN0 : IDLE;
        end else if (p0_req) begin
          p1_gnt       = 1'b1;
          last_gnt_nxt = 1'b1;
          hold_cnt_nxt = '0;
          state_nxt    = p1_lock ? OWN1 : IDLE;
        end else begin
          p1_gnt       = p1_req;
          hold_cnt_nxt = '0;
          state_nxt    = IDLE;
          if (p1_req) begin
            last_gnt_nxt = 1'b1;
            state_nxt    = p1_lock ? OWN1 : IDLE;
          end
        end
      end
      OWN1: begin
        if (p1_req && (!p0_req || hold_cnt < HCNT_W'(MAX_HOLD))) begin
          p1_gnt       = 1'b1;
          last_gnt_nxt = 1'b1;
          hold_cnt_nxt = p0_req ? hold_cnt + 1'b1 : '0;
          state_nxt    = p1_lock ? OWN1 : IDLE;
        end else if (p1_req) begin
          p0_gnt       = 1'b1;
          last_gnt_nxt = 1'b0;
          hold_cnt_nxt = '0;
          state_nxt    = p0_lock ? OWN0 : IDLE;
        end else begin
          p0_gnt       = p0_req;
          hold_cnt_nxt = '0;
          state_nxt    = IDLE;
          if (p0_req) begin
            last_gnt_nxt = 1'b0;
            state_nxt    = p0_lock ? OWN0 : IDLE;
          end
        end
      end
      default: begin
        p0_gnt       = arb_g0;
        p1_gnt       = arb_g1;
        hold_cnt_nxt = '0;
        state_nxt    = IDLE;
        if (arb_g0) begin
          last_gnt_nxt = 1'b0;
          state_nxt    = p0_lock ? OWN0 : IDLE;
        end else if (arb_g1) begin
          last_gnt_nxt = 1'b1;
          state_nxt    = p1_lock ? OWN1 : IDLE;
        end
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Granted port's access muxed onto the SRAM core pins
  always_comb begin
    acc           = p0_gnt | p1_gnt;
    sel_wr        = p1_gnt ? p1_wr    : p0_wr;
    sel_addr      = p1_gnt ? p1_addr  : p0_addr;
    sel_be        = p1_gnt ? p1_be    : p0_be;
    sel_wdata     = p1_gnt ? p1_wdata : p0_wdata;
    sram_w_en     = 1'b1;
    sram_addr_out = '0;
    sram_wdata    = '0;
    bank0_csn     = '1;
    bank1_csn     = '1;
    if (acc) begin
      sram_w_en     = ~sel_wr;
      sram_addr_out = sel_addr[14:2];
      sram_wdata    = sel_wdata;
      if (sel_addr[15]) bank1_csn = ~sel_be;
      else              bank0_csn = ~sel_be;
    end
  end

  // Capture what a read needs to steer its data back next cycle
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      rd_pend <= 1'b0;
      rd_port <= 1'b0;
      rd_bank <= 1'b0;
      rd_be   <= '0;
    end else begin
      rd_pend <= acc & ~sel_wr;
      rd_port <= p1_gnt;
      rd_bank <= sel_addr[15];
      rd_be   <= sel_be;
    end
  end

  // Read data return: byte-masked bank word on the requesting port only
  always_comb begin
    bank_word = rd_bank ? {sram_q7, sram_q6, sram_q5, sram_q4}
                        : {sram_q3, sram_q2, sram_q1, sram_q0};
    rd_word   = bank_word & {{8{rd_be[3]}}, {8{rd_be[2]}}, {8{rd_be[1]}}, {8{rd_be[0]}}};
    p0_rvalid = rd_pend & ~rd_port;
    p1_rvalid = rd_pend &  rd_port;
    p0_rdata  = p0_rvalid ? rd_word : '0;
    p1_rdata  = p1_rvalid ? rd_word : '0;
  end

endmodule
